// File: rtl/pulse_burst_controller.sv
// Programmable strobe-burst sequencer: delay, width, period and count are latched
// on an accepted start; the train can be cancelled at any time with abort.
module pulse_burst_controller #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] pulse_idx
);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt;
   logic [CNT_W-1:0] r_width_m1, r_low_m1, r_last_idx;
   logic             w_cfg_ok, w_load, w_done_nxt, w_err_nxt;
   logic             r_pulse, r_busy, r_done, r_cfg_err;

   assign w_cfg_ok = (cfg_width != '0) && (cfg_count != '0) && (cfg_width < cfg_period);

   // Each phase loads its length minus one and leaves when the counter reaches zero.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_cfg_ok) begin
                     w_load    = 1'b1;
                     w_idx_nxt = '0;
                     if (cfg_delay == '0) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = cfg_width - 1'b1;
                     end else begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = cfg_delay - 1'b1;
                     end
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end
            end
            S_DELAY: begin
               if (r_cnt == '0) begin
                  w_state_nxt = S_HIGH;
                  w_cnt_nxt   = r_width_m1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_HIGH: begin
               if (r_cnt == '0) begin
                  if (r_idx == r_last_idx) begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_LOW;
                     w_cnt_nxt   = r_low_m1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_LOW: begin
               if (r_cnt == '0) begin
                  w_state_nxt = S_HIGH;
                  w_cnt_nxt   = r_width_m1;
                  w_idx_nxt   = r_idx + 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so all registers update together.
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_width_m1 <= '0;
         r_low_m1   <= '0;
         r_last_idx <= '0;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_pulse   <= (w_state_nxt == S_HIGH);
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= w_done_nxt;
         r_cfg_err <= w_err_nxt;
         // Phase lengths are stored pre-decremented so the running burst needs no subtractors.
         if (w_load) begin
            r_width_m1 <= cfg_width - 1'b1;
            r_low_m1   <= cfg_period - cfg_width - 1'b1;
            r_last_idx <= cfg_count - 1'b1;
         end
      end
   end

   assign pulse     = r_pulse;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cfg_err   = r_cfg_err;
   assign pulse_idx = r_idx;

endmodule
